// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : digit_scan_ctrl
//  Purpose  : Multiplexed BCD display scan driver with per-slot blanking.
//  Revision : 1.0 - initial release
// ============================================================================
module digit_scan_ctrl #(
    parameter int PRESCALE       = 50000,
    parameter int BLANK_CYCLES   = 100,
    parameter int NUM_DIGITS     = 8,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] digit_val,
    input  logic [7:0] blank_mask,
    input  logic [7:0] dp_mask,
    output logic [2:0] sel,
    output logic [7:0] dig_en,
    output logic [3:0] bcd_out,
    output logic       dp,
    output logic       frame_tick,
    output logic       bcd_err
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CW-1:0] c_cnt_last  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] c_cnt_cap   = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] c_cnt_one   = CW'(1);
    localparam logic [2:0]    c_sel_last  = 3'(NUM_DIGITS - 1);
    localparam logic [7:0]    c_dig_off   = (DIG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [7:0]    c_dig_valid = 8'((16'd1 << NUM_DIGITS) - 16'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_sel;
    logic [7:0]      r_dig_en;
    logic [3:0]      r_bcd;
    logic            r_dp;
    logic            r_frame_tick;
    logic            r_bcd_err;

    logic            w_slot_end;
    logic [2:0]      w_sel_next;
    logic [7:0]      w_onehot;
    logic            w_cap_bad;
    logic            w_bcd_bad;

    assign w_slot_end = (r_state != ST_IDLE) && (r_cnt == c_cnt_last);
    assign w_sel_next = (r_sel == c_sel_last) ? 3'd0 : r_sel + 3'd1;
    assign w_onehot   = (8'd1 << r_sel) & c_dig_valid;
    assign w_cap_bad  = (digit_val > 4'd9);
    assign w_bcd_bad  = (r_bcd > 4'd9);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_sel        <= 3'd0;
            r_dig_en     <= c_dig_off;
            r_bcd        <= 4'd0;
            r_dp         <= 1'b0;
            r_frame_tick <= 1'b0;
            r_bcd_err    <= 1'b0;
        end else if (!en) begin
            // bcd_out deliberately holds so the last shown value survives a pause
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_sel        <= 3'd0;
            r_dig_en     <= c_dig_off;
            r_dp         <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state      <= ST_BLANK;
                    r_cnt        <= '0;
                    r_sel        <= 3'd0;
                    r_dig_en     <= c_dig_off;
                    r_frame_tick <= 1'b1;
                end
                default: begin
                    if (w_slot_end) begin
                        // sel and the dark enables move on the same edge: no ghosting
                        r_state      <= ST_BLANK;
                        r_cnt        <= '0;
                        r_sel        <= w_sel_next;
                        r_dig_en     <= c_dig_off;
                        r_dp         <= 1'b0;
                        r_frame_tick <= (w_sel_next == 3'd0);
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                        if (r_state == ST_BLANK) begin
                            if (r_cnt == c_cnt_cap) begin
                                r_state   <= ST_SHOW;
                                r_bcd     <= digit_val;
                                r_dp      <= dp_mask[r_sel];
                                r_bcd_err <= r_bcd_err | w_cap_bad;
                                r_dig_en  <= (blank_mask[r_sel] || w_cap_bad) ?
                                             c_dig_off : (c_dig_off ^ w_onehot);
                            end
                        end else begin
                            r_state  <= ST_SHOW;
                            r_dig_en <= (blank_mask[r_sel] || w_bcd_bad) ?
                                        c_dig_off : (c_dig_off ^ w_onehot);
                        end
                    end
                end
            endcase
        end
    end

    assign sel        = r_sel;
    assign dig_en     = r_dig_en;
    assign bcd_out    = r_bcd;
    assign dp         = r_dp;
    assign frame_tick = r_frame_tick;
    assign bcd_err    = r_bcd_err;

endmodule
`default_nettype wire
